axi_rd_slave: RTL and testbench



---
 rtl/axi_rd_slave_pkg.sv | 25 ++
 rtl/axi_rd_beat_fifo.sv | 70 +++++++
 rtl/axi_rd_slave_chk.sv | 21 ++
 rtl/axi_rd_slave.sv | 189 ++++++++++++++++++
 tb/tb_axi_rd_slave.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_rd_slave_pkg.sv
// Shared constants, FSM encoding and request checking for the AXI4 read-channel responder.
package axi_rd_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // Only full-width FIXED or INCR bursts are served from memory; anything else answers SLVERR.
  function automatic logic req_is_err(input logic [1:0] burst, input logic [2:0] size,
                                      input logic [2:0] beat_size);
    return !((burst == BURST_FIXED) || (burst == BURST_INCR)) || (size != beat_size);
  endfunction

endpackage

// File: rtl/axi_rd_beat_fifo.sv
// First-word-fall-through beat FIFO; a push into a full FIFO is taken only when a pop frees the slot.
module axi_rd_beat_fifo #(
  parameter int W     = 35,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam logic [CW-1:0] DEPTH_V = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_s, do_pop_s;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d     = mem_q;
    do_pop_s  = pop && (count_q != '0);
    do_push_s = push && ((count_q != DEPTH_V) || do_pop_s);
    if (do_push_s) begin
      mem_d[wptr_q] = din;
      wptr_d        = wptr_q + AW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (do_pop_s) begin
      rptr_d = rptr_q + AW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign dout  = mem_q[rptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_V);

endmodule

// File: rtl/axi_rd_slave_chk.sv
// Simulation checks on the beat FIFO credit scheme.
module axi_rd_slave_chk #(
  parameter int CW    = 3,
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  input logic          push,
  input logic          pop,
  input logic          full,
  input logic [CW-1:0] count,
  input logic [CW-1:0] inflight
);

  localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
  a_credit:      assert property (@(posedge clk) disable iff (!rst_n)
                                  ({1'b0, count} + {1'b0, inflight}) <= DEPTH_V);

endmodule

// File: rtl/axi_rd_slave.sv
// AXI4 read-channel responder: one AR at a time, beats fetched from a local memory read port
// and returned on R through a credit-limited beat FIFO.
module axi_rd_slave
  import axi_rd_slave_pkg::*;
#(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH         = 10,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] MEM_BASE_ADDR = '0,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [7:0]                    S_AXI_ARLEN,
  input  logic [2:0]                    S_AXI_ARSIZE,
  input  logic [1:0]                    S_AXI_ARBURST,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RLAST,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic                          rd_en,
  output logic [ADDR_WIDTH-1:0]         rd_addr,
  input  logic                          rd_dat_vld,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] rd_dat
);

  localparam int          DW         = C_S_AXI_DATA_WIDTH;
  localparam int          BEAT_SHIFT = $clog2(DW / 8);
  localparam logic [2:0]  BEAT_SIZE  = 3'(BEAT_SHIFT);
  localparam int          FW         = DW + 3;
  localparam int          CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(FIFO_DEPTH);

  state_e                        state_q, state_d;
  logic                          arready_q, arready_d;
  logic [C_S_AXI_ID_WIDTH-1:0]   id_q, id_d;
  logic [7:0]                    len_q, len_d, issue_cnt_q, issue_cnt_d, push_cnt_q, push_cnt_d;
  logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
  logic                          fixed_q, fixed_d, err_q, err_d;
  logic [CW-1:0]                 inflight_q, inflight_d;

  logic [C_S_AXI_ADDR_WIDTH-1:0] off_s;
  logic [ADDR_WIDTH-1:0]         word_s;
  logic                          credit_ok_s, issue_s, rd_en_s, mem_push_s, push_s, r_hs_s;
  logic [FW-1:0]                 fifo_din_s, fifo_dout_s;
  logic [CW-1:0]                 fifo_count_s;
  logic                          fifo_empty_s, fifo_full_s;

  assign off_s       = S_AXI_ARADDR - MEM_BASE_ADDR;
  assign word_s      = ADDR_WIDTH'(off_s >> BEAT_SHIFT);
  assign credit_ok_s = ({1'b0, fifo_count_s} + {1'b0, inflight_q}) < CREDIT_MAX;
  assign r_hs_s      = !fifo_empty_s && S_AXI_RREADY;

  // Request FSM: accept, issue one beat per credit, then wait for the RLAST handshake.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    len_d       = len_q;
    addr_d      = addr_q;
    fixed_d     = fixed_q;
    err_d       = err_q;
    issue_cnt_d = issue_cnt_q;
    issue_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (S_AXI_ARVALID && arready_q) begin
          id_d        = S_AXI_ARID;
          len_d       = S_AXI_ARLEN;
          addr_d      = word_s;
          fixed_d     = (S_AXI_ARBURST == BURST_FIXED);
          err_d       = req_is_err(S_AXI_ARBURST, S_AXI_ARSIZE, BEAT_SIZE);
          issue_cnt_d = 8'd0;
          state_d     = S_BURST;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BURST: begin
        if (credit_ok_s) begin
          issue_s     = 1'b1;
          issue_cnt_d = issue_cnt_q + 8'd1;
          addr_d      = fixed_q ? addr_q : addr_q + ADDR_WIDTH'(1);
          state_d     = (issue_cnt_q == len_q) ? S_DRAIN : S_BURST;
        end else begin
          state_d = S_BURST;
        end
      end
      S_DRAIN: begin
        if (r_hs_s && fifo_dout_s[FW-1]) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
    arready_d = (state_d == S_IDLE);
  end

  // Beat datapath: error beats bypass memory; stray data with nothing in flight is dropped.
  always_comb begin
    rd_en_s    = issue_s && !err_q;
    mem_push_s = rd_dat_vld && (inflight_q != '0);
    push_s     = mem_push_s || (issue_s && err_q);
    if (err_q) begin
      fifo_din_s = {(push_cnt_q == len_q), RESP_SLVERR, {DW{1'b0}}};
    end else begin
      fifo_din_s = {(push_cnt_q == len_q), RESP_OKAY, rd_dat};
    end
    if (state_q == S_IDLE) begin
      push_cnt_d = 8'd0;
    end else if (push_s) begin
      push_cnt_d = push_cnt_q + 8'd1;
    end else begin
      push_cnt_d = push_cnt_q;
    end
    case ({rd_en_s, mem_push_s})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // Control and request registers.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q     <= S_IDLE;
      arready_q   <= 1'b0;
      id_q        <= '0;
      len_q       <= 8'd0;
      addr_q      <= '0;
      fixed_q     <= 1'b0;
      err_q       <= 1'b0;
      issue_cnt_q <= 8'd0;
      push_cnt_q  <= 8'd0;
      inflight_q  <= '0;
    end else begin
      state_q     <= state_d;
      arready_q   <= arready_d;
      id_q        <= id_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      fixed_q     <= fixed_d;
      err_q       <= err_d;
      issue_cnt_q <= issue_cnt_d;
      push_cnt_q  <= push_cnt_d;
      inflight_q  <= inflight_d;
    end
  end

  axi_rd_beat_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .push  (push_s),
    .din   (fifo_din_s),
    .pop   (r_hs_s),
    .dout  (fifo_dout_s),
    .count (fifo_count_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

  axi_rd_slave_chk #(.CW(CW), .DEPTH(FIFO_DEPTH)) u_chk (
    .clk      (S_AXI_ACLK),
    .rst_n    (S_AXI_ARESETN),
    .push     (push_s),
    .pop      (r_hs_s),
    .full     (fifo_full_s),
    .count    (fifo_count_s),
    .inflight (inflight_q)
  );

  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = !fifo_empty_s;
  assign S_AXI_RLAST   = fifo_dout_s[FW-1];
  assign S_AXI_RRESP   = fifo_dout_s[FW-2:FW-3];
  assign S_AXI_RDATA   = fifo_dout_s[DW-1:0];
  assign S_AXI_RID     = id_q;
  assign rd_en         = rd_en_s;
  assign rd_addr       = addr_q;

endmodule

// File: tb/tb_axi_rd_slave.sv
// Bench for axi_rd_slave: directed vector table, hand-written corner sequences and random bursts
// checked beat-by-beat against a queue-based model of the AXI read rules.
module tb_axi_rd_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [0:0]  arid = 1'b0;
  logic [31:0] araddr = 32'h0;
  logic [7:0]  arlen = 8'd0;
  logic [2:0]  arsize = 3'd0;
  logic [1:0]  arburst = 2'd0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [0:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid;
  logic        rready = 1'b0;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic        rd_dat_vld = 1'b0;
  logic [31:0] rd_dat = 32'h0;

  always #5 clk = ~clk;

  axi_rd_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
    .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_dat_vld(rd_dat_vld), .rd_dat(rd_dat)
  );

  // beat = {rid, rresp, rlast, rdata}
  typedef logic [35:0] beat_t;

  typedef struct {
    logic [0:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          rmode;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    logic [1:0]  exp_resp;
    int          exp_rden;
  } vec_t;

  logic [31:0] mem [1024];
  beat_t exp_q[$];
  beat_t got_q[$];
  int    got_cyc[$];
  int    exp_idx = 0;
  int    total = 0, bad = 0;
  int    cyc = 0;
  int    issued_total = 0, popped_total = 0;
  int    rmode = 0;
  int    hs_cyc = 0;
  logic  prev_stall = 1'b0, chk_arready = 1'b0;
  beat_t prev_beat = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // 1-cycle-latency memory.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_dat_vld <= rd_en;
    rd_dat <= rd_en ? mem[rd_addr] : 32'hDEAD_BEEF;
    if (rd_en) issued_total <= issued_total + 1;
  end

  // RREADY patterns: 0 always ready, 1 repeating 1,0,0, 2 random.
  initial begin
    int pat;
    pat = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        1: begin rready = (pat == 0); pat = (pat + 1) % 3; end
        2: rready = 1'($urandom_range(0, 1));
        default: rready = 1'b1;
      endcase
    end
  end

  // R channel monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall   = 1'b0;
      chk_arready  = 1'b0;
      exp_idx      = exp_q.size();
      popped_total = issued_total;
    end else begin
      if (rd_en || rvalid) check("credit_le_depth", 64'((issued_total - popped_total) <= 4), 64'd1);
      if (chk_arready) begin
        check("arready_after_rlast", 64'(arready), 64'd1);
        chk_arready = 1'b0;
      end
      if (prev_stall) check("r_hold_stable", {rvalid, rid, rresp, rlast, rdata}, {1'b1, prev_beat});
      if (rvalid && rready) begin
        if (exp_idx < exp_q.size()) begin
          check("beat", {rid, rresp, rlast, rdata}, exp_q[exp_idx]);
          exp_idx++;
        end else begin
          total++;
          bad++;
          $display("FAIL beat_unexpected: got 0x%0h expected no beat", {rid, rresp, rlast, rdata});
        end
        got_q.push_back({rid, rresp, rlast, rdata});
        got_cyc.push_back(cyc);
        if (rresp == 2'b00) popped_total++;
        if (rlast) chk_arready = 1'b1;
      end
      prev_stall = rvalid && !rready;
      prev_beat  = {rid, rresp, rlast, rdata};
    end
  end

  task automatic model_burst(input logic [0:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    bit err;
    int w;
    err = (burst > 2'd1) || (size != 3'd2);
    w = int'(addr >> 2) % 1024;
    for (int i = 0; i <= int'(len); i++) begin
      exp_q.push_back({id, err ? 2'b10 : 2'b00, 1'(i == int'(len)), err ? 32'h0 : mem[w]});
      if (burst == 2'd1) w = (w + 1) % 1024;
    end
  endtask

  task automatic send_ar(input logic [0:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output int waited);
    waited = 0;
    @(negedge clk);
    while (arready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) begin
      check("ar_accept_timeout", 64'(arready), 64'd1);
    end else begin
      model_burst(id, addr, len, size, burst);
      arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
      arvalid = 1'b1;
      hs_cyc = cyc;
      @(negedge clk);
      arvalid = 1'b0;
      check("arready_drop", 64'(arready), 64'd0);
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (exp_idx < exp_q.size() && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 3000) check("burst_timeout", 64'(exp_q.size() - exp_idx), 64'd0);
  endtask

  vec_t vec[8];

  initial begin
    int w, b0, r0, n, t;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
    vec[0] = '{1'b1, 32'h0000_0000, 8'd7, 3'd2, 2'd1, 0, 32'd0,    32'd7, 2'b00, 8};
    vec[1] = '{1'b1, 32'h0000_0000, 8'd7, 3'd2, 2'd1, 1, 32'd0,    32'd7, 2'b00, 8};
    vec[2] = '{1'b0, 32'h0000_0010, 8'd3, 3'd2, 2'd0, 0, 32'd4,    32'd4, 2'b00, 4};
    vec[3] = '{1'b0, 32'h0000_0FF8, 8'd3, 3'd2, 2'd1, 0, 32'd1022, 32'd1, 2'b00, 4};
    vec[4] = '{1'b1, 32'h0000_0000, 8'd3, 3'd2, 2'd2, 0, 32'd0,    32'd0, 2'b10, 0};
    vec[5] = '{1'b0, 32'h0000_0020, 8'd1, 3'd3, 2'd1, 1, 32'd0,    32'd0, 2'b10, 0};
    vec[6] = '{1'b1, 32'h0000_0040, 8'd0, 3'd2, 2'd3, 0, 32'd0,    32'd0, 2'b10, 0};
    vec[7] = '{1'b0, 32'h0000_1008, 8'd0, 3'd2, 2'd1, 2, 32'd2,    32'd2, 2'b00, 1};

    #1 rst_n = 1'b0;
    #20;
    check("reset_outputs", {arready, rvalid, rlast, rdata, rresp, rid, rd_en, rd_addr}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("arready_after_reset", 64'(arready), 64'd1);

    for (int i = 0; i < 8; i++) begin
      rmode = vec[i].rmode;
      b0 = got_q.size();
      r0 = issued_total;
      send_ar(vec[i].id, vec[i].addr, vec[i].len, vec[i].size, vec[i].burst, w);
      wait_done();
      n = got_q.size() - b0;
      check("beat_count", 64'(n), 64'(int'(vec[i].len) + 1));
      if (n > 0) begin
        check("first_data", 64'(got_q[b0][31:0]), 64'(vec[i].exp_first));
        check("last_data", 64'(got_q[got_q.size()-1][31:0]), 64'(vec[i].exp_last));
        check("last_resp", 64'(got_q[got_q.size()-1][34:33]), 64'(vec[i].exp_resp));
        if (rmode == 0 && vec[i].exp_resp == 2'b00)
          check("first_rvalid_latency", 64'(got_cyc[b0] - hs_cyc), 64'd3);
      end
      check("rd_en_count", 64'(issued_total - r0), 64'(vec[i].exp_rden));
    end

    // ARLEN=0 followed at once by a second request.
    rmode = 0;
    b0 = got_q.size();
    send_ar(1'b0, 32'h0000_0020, 8'd0, 3'd2, 2'd1, w);
    wait_done();
    send_ar(1'b1, 32'h0000_0040, 8'd2, 3'd2, 2'd1, w);
    check("b2b_accept_wait", 64'(w), 64'd0);
    wait_done();
    check("b2b_beats", 64'(got_q.size() - b0), 64'd4);
    if (got_q.size() - b0 == 4) begin
      check("b2b_single", 64'(got_q[b0]), 64'({1'b0, 2'b00, 1'b1, 32'd8}));
      check("b2b_second_last", 64'(got_q[b0+3]), 64'({1'b1, 2'b00, 1'b1, 32'd18}));
    end

    // Reset in the middle of an 8-beat burst.
    b0 = got_q.size();
    send_ar(1'b1, 32'h0000_0000, 8'd7, 3'd2, 2'd1, w);
    t = 0;
    while (got_q.size() - b0 < 3 && t < 200) begin
      @(posedge clk);
      t++;
    end
    check("reset_test_beats", 64'(got_q.size() - b0), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {arready, rvalid, rlast, rdata, rresp, rid, rd_en, rd_addr}, 64'd0);
    #10;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("arready_after_midreset", 64'(arready), 64'd1);
    b0 = got_q.size();
    r0 = issued_total;
    send_ar(1'b0, 32'h0000_0100, 8'd5, 3'd2, 2'd1, w);
    wait_done();
    check("post_reset_beats", 64'(got_q.size() - b0), 64'd6);
    check("post_reset_rd_en", 64'(issued_total - r0), 64'd6);

    // Random bursts against the model.
    for (int k = 0; k < 25; k++) begin
      logic [0:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      int          sel;
      id   = 1'($urandom_range(0, 1));
      addr = $urandom;
      len  = 8'($urandom_range(0, 15));
      sel  = $urandom_range(0, 9);
      burst = (sel < 4) ? 2'd1 : (sel < 7) ? 2'd0 : (sel < 8) ? 2'd2 : 2'd3;
      size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      rmode = $urandom_range(0, 2);
      b0 = got_q.size();
      r0 = issued_total;
      send_ar(id, addr, len, size, burst, w);
      wait_done();
      check("rand_beats", 64'(got_q.size() - b0), 64'(int'(len) + 1));
      check("rand_rd_en", 64'(issued_total - r0),
            ((burst > 2'd1) || (size != 3'd2)) ? 64'd0 : 64'(int'(len) + 1));
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
